// File: rtl/rx_fifo_ctrl_pkg.sv
// Shared types for the RX FIFO write-side controller: FSM state encoding and drop reason codes.
package rx_fifo_ctrl_pkg;

    typedef logic [1:0] rxc_state_t;

    localparam rxc_state_t IDLE    = 2'd0;
    localparam rxc_state_t WRITE   = 2'd1;
    localparam rxc_state_t DISCARD = 2'd2;
    localparam rxc_state_t COMMIT  = 2'd3;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        BAD_FRAME = 3'd1,
        OVERFLOW  = 3'd2,
        TOO_LONG  = 3'd3,
        TOO_SHORT = 3'd4,
        NO_ROOM   = 3'd5
    } drop_reason_t;

endpackage

// File: rtl/rx_fifo_wr_ctrl.sv
// Streams RX MAC frames into the packet FIFO and commits (latch_addr) or rewinds (drop_pckt) each one.
// Define RX_FIFO_WR_CTRL_STATS_EN to add good/drop/overflow statistics counters.
module rx_fifo_wr_ctrl
    import rx_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MIN_PKT_LEN = 64,
    parameter int MAX_PKT_LEN = 1518,
    parameter int LEN_WIDTH   = 16,
    parameter int STAT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_wr_en,
    output logic                  fifo_latch_addr,
    output logic                  fifo_drop_pckt,
    input  logic                  fifo_full,
    input  logic                  fifo_almost_full,
    output logic                  pkt_done,
    output logic                  pkt_dropped,
`ifdef RX_FIFO_WR_CTRL_STATS_EN
    output logic [STAT_WIDTH-1:0] stat_good_cnt,
    output logic [STAT_WIDTH-1:0] stat_drop_cnt,
    output logic [STAT_WIDTH-1:0] stat_ovf_cnt,
`endif
    output logic [2:0]            drop_reason
);

    localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(MIN_PKT_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PKT_LEN);

    rxc_state_t           state;
    logic [LEN_WIDTH-1:0] len;
    logic                 err;
    logic                 tuser_last;
    drop_reason_t         reason;

    logic                 accept;
    logic                 ovf_now;
    logic                 len_at_max;
    logic [LEN_WIDTH-1:0] len_inc;
    logic                 wr_now;
    logic                 too_long_now;
    drop_reason_t         commit_reason;
    logic                 commit_drop;

    assign s_axis_tready = (state != COMMIT);
    assign accept        = s_axis_tvalid & s_axis_tready;
    // A write presented while the FIFO is full is lost, so the frame can no longer be committed.
    assign ovf_now       = fifo_wr_en & fifo_full;
    assign len_at_max    = (len >= MAX_LEN);
    assign len_inc       = (len == '1) ? len : len + 1'b1;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_now       = 1'b0;
        too_long_now = 1'b0;
        case (state)
            IDLE: wr_now = accept & ~fifo_almost_full;
            WRITE: begin
                too_long_now = accept & len_at_max & ~ovf_now;
                wr_now       = accept & ~len_at_max & ~ovf_now;
            end
            default: ;
        endcase
    end

    // Earlier recorded errors win; commit-time checks only classify an otherwise clean frame.
    always_comb begin
        commit_reason = NONE;
        if (err)
            commit_reason = reason;
        else if (ovf_now)
            commit_reason = OVERFLOW;
        else if (tuser_last)
            commit_reason = BAD_FRAME;
        else if (len < MIN_LEN)
            commit_reason = TOO_SHORT;
    end

    assign commit_drop = (commit_reason != NONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            len             <= '0;
            err             <= 1'b0;
            tuser_last      <= 1'b0;
            reason          <= NONE;
            fifo_data       <= '0;
            fifo_wr_en      <= 1'b0;
            fifo_latch_addr <= 1'b0;
            fifo_drop_pckt  <= 1'b0;
            pkt_done        <= 1'b0;
            pkt_dropped     <= 1'b0;
            drop_reason     <= 3'd0;
        end else begin
            fifo_wr_en      <= wr_now;
            fifo_latch_addr <= 1'b0;
            fifo_drop_pckt  <= 1'b0;
            pkt_done        <= 1'b0;
            pkt_dropped     <= 1'b0;
            drop_reason     <= 3'd0;
            if (wr_now)
                fifo_data <= s_axis_tdata;
            if (accept)
                tuser_last <= s_axis_tuser & s_axis_tlast;

            case (state)
                IDLE: begin
                    if (accept) begin
                        len    <= LEN_WIDTH'(1);
                        err    <= fifo_almost_full;
                        reason <= fifo_almost_full ? NO_ROOM : NONE;
                        if (s_axis_tlast)
                            state <= COMMIT;
                        else
                            state <= fifo_almost_full ? DISCARD : WRITE;
                    end
                end
                WRITE: begin
                    if (ovf_now) begin
                        err    <= 1'b1;
                        reason <= OVERFLOW;
                    end else if (too_long_now) begin
                        err    <= 1'b1;
                        reason <= TOO_LONG;
                    end
                    if (accept)
                        len <= len_inc;
                    if (accept && s_axis_tlast)
                        state <= COMMIT;
                    else if (ovf_now || too_long_now)
                        state <= DISCARD;
                end
                DISCARD: begin
                    if (accept) begin
                        len <= len_inc;
                        if (s_axis_tlast)
                            state <= COMMIT;
                    end
                end
                COMMIT: begin
                    pkt_done        <= 1'b1;
                    pkt_dropped     <= commit_drop;
                    fifo_drop_pckt  <= commit_drop;
                    fifo_latch_addr <= ~commit_drop;
                    drop_reason     <= commit_reason;
                    reason          <= commit_reason;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RX_FIFO_WR_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_good_cnt <= '0;
            stat_drop_cnt <= '0;
            stat_ovf_cnt  <= '0;
        end else if (state == COMMIT) begin
            if (commit_drop)
                stat_drop_cnt <= stat_drop_cnt + 1'b1;
            else
                stat_good_cnt <= stat_good_cnt + 1'b1;
            if (commit_reason == OVERFLOW || commit_reason == NO_ROOM)
                stat_ovf_cnt <= stat_ovf_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_fifo_wr_ctrl.sv
// Self-checking bench for rx_fifo_wr_ctrl: table of frame vectors plus back-to-back and reset sequences.
module tb_rx_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tlast;
    logic       s_axis_tuser;
    logic       s_axis_tready;
    logic [7:0] fifo_data;
    logic       fifo_wr_en;
    logic       fifo_latch_addr;
    logic       fifo_drop_pckt;
    logic       fifo_full;
    logic       fifo_almost_full;
    logic       pkt_done;
    logic       pkt_dropped;
    logic [2:0] drop_reason;
`ifdef RX_FIFO_WR_CTRL_STATS_EN
    logic [31:0] stat_good_cnt;
    logic [31:0] stat_drop_cnt;
    logic [31:0] stat_ovf_cnt;
`endif

    rx_fifo_wr_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tready    (s_axis_tready),
        .fifo_data        (fifo_data),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_latch_addr  (fifo_latch_addr),
        .fifo_drop_pckt   (fifo_drop_pckt),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .pkt_done         (pkt_done),
        .pkt_dropped      (pkt_dropped),
`ifdef RX_FIFO_WR_CTRL_STATS_EN
        .stat_good_cnt    (stat_good_cnt),
        .stat_drop_cnt    (stat_drop_cnt),
        .stat_ovf_cnt     (stat_ovf_cnt),
`endif
        .drop_reason      (drop_reason)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        bit         tuser;
        int         full_beat;
        bit         af;
        int         exp_wr;
        bit         exp_drop;
        logic [2:0] exp_reason;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    int checks   = 0;
    int failures = 0;

    int         wr_cnt, latch_cnt, drop_cnt, data_err, stall_cnt;
    int         excl_err = 0;
    logic       last_dropped;
    logic [2:0] last_reason;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle observer of the FIFO side, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (fifo_wr_en) begin
                if (fifo_data !== 8'(wr_cnt + 1))
                    data_err++;
                wr_cnt++;
            end
            if (fifo_latch_addr) latch_cnt++;
            if (fifo_drop_pckt)  drop_cnt++;
            if (pkt_done) begin
                last_dropped = pkt_dropped;
                last_reason  = drop_reason;
            end
            if ((fifo_latch_addr && fifo_drop_pckt) ||
                ((fifo_latch_addr || fifo_drop_pckt) && fifo_wr_en) ||
                ((fifo_latch_addr || fifo_drop_pckt) !== pkt_done) ||
                (pkt_dropped !== fifo_drop_pckt))
                excl_err++;
            if (s_axis_tvalid && !s_axis_tready)
                stall_cnt++;
        end
    end

    task automatic clr();
        wr_cnt       = 0;
        latch_cnt    = 0;
        drop_cnt     = 0;
        data_err     = 0;
        stall_cnt    = 0;
        last_dropped = 1'b0;
        last_reason  = 3'd7;
    endtask

    // Drives n beats with tvalid held high; entered and left #1 after a rising edge.
    task automatic send_beats(input int n, input bit tuser, input int full_beat, input bit af, input bit last);
        for (int i = 1; i <= n; i++) begin
            bit acc   = 1'b0;
            int tries = 0;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 8'(i);
            s_axis_tlast  = last && (i == n);
            s_axis_tuser  = tuser && (i == n);
            if (i == 1) fifo_almost_full = af;
            while (!acc) begin
                @(negedge clk);
                acc = s_axis_tready;
                @(posedge clk);
                #1;
                tries++;
                if (!acc && tries > 8) begin
                    failures++;
                    $display("FAIL beat_accept: tready got 0 required 1 (beat %0d)", i);
                    $fatal(1);
                end
            end
            fifo_almost_full = 1'b0;
            fifo_full        = (i == full_beat);
        end
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int lat = -1;
        clr();
        send_beats(v.len, v.tuser, v.full_beat, v.af, 1'b1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (pkt_done) begin
                lat = k;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'd2);
        check($sformatf("v%0d_writes", idx), 32'(wr_cnt), 32'(v.exp_wr));
        check($sformatf("v%0d_latch", idx), 32'(latch_cnt), v.exp_drop ? 32'd0 : 32'd1);
        check($sformatf("v%0d_drop", idx), 32'(drop_cnt), v.exp_drop ? 32'd1 : 32'd0);
        check($sformatf("v%0d_dropped", idx), 32'(last_dropped), 32'(v.exp_drop));
        check($sformatf("v%0d_reason", idx), 32'(last_reason), 32'(v.exp_reason));
        check($sformatf("v%0d_data", idx), 32'(data_err), 32'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_outs"}, 32'({fifo_wr_en, fifo_data, fifo_latch_addr, fifo_drop_pckt,
                                    pkt_done, pkt_dropped, drop_reason}), 32'd0);
        check({name, "_tready"}, 32'(s_axis_tready), 32'd1);
    endtask

    initial begin
        int exp_good = 0;
        int exp_drop = 0;
        int exp_ovf  = 0;
        vec_t good64;

        //          len   tuser full af  exp_wr drop reason
        vecs[0] = '{100,  1'b0, 0,  1'b0, 100,  1'b0, 3'd0};  // clean frame
        vecs[1] = '{80,   1'b1, 0,  1'b0, 80,   1'b1, 3'd1};  // bad FCS
        vecs[2] = '{60,   1'b0, 0,  1'b0, 60,   1'b1, 3'd4};  // runt
        vecs[3] = '{1600, 1'b0, 0,  1'b0, 1518, 1'b1, 3'd3};  // giant
        vecs[4] = '{200,  1'b0, 30, 1'b0, 30,   1'b1, 3'd2};  // overflow at beat 30
        vecs[5] = '{64,   1'b0, 0,  1'b1, 0,    1'b1, 3'd5};  // no room at SOF
        vecs[6] = '{64,   1'b0, 0,  1'b0, 64,   1'b0, 3'd0};  // minimum legal
        vecs[7] = '{1518, 1'b0, 0,  1'b0, 1518, 1'b0, 3'd0};  // maximum legal
        vecs[8] = '{1,    1'b0, 0,  1'b0, 1,    1'b1, 3'd4};  // single-beat frame
        vecs[9] = '{1519, 1'b0, 0,  1'b0, 1518, 1'b1, 3'd3};  // one past maximum
        good64  = vecs[6];

        reset_n          = 1'b0;
        s_axis_tdata     = '0;
        s_axis_tvalid    = 1'b0;
        s_axis_tlast     = 1'b0;
        s_axis_tuser     = 1'b0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        clr();

        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_frame(vecs[i], i);
            if (vecs[i].exp_drop) exp_drop++;
            else                  exp_good++;
            if (vecs[i].exp_reason == 3'd2 || vecs[i].exp_reason == 3'd5) exp_ovf++;
        end

`ifdef RX_FIFO_WR_CTRL_STATS_EN
        check("stat_good", stat_good_cnt, 32'(exp_good));
        check("stat_drop", stat_drop_cnt, 32'(exp_drop));
        check("stat_ovf",  stat_ovf_cnt,  32'(exp_ovf));
`endif

        // Two back-to-back legal frames, then reset in the middle of a third.
        clr();
        send_beats(64, 1'b0, 0, 1'b0, 1'b1);
        send_beats(64, 1'b0, 0, 1'b0, 1'b1);
        send_beats(10, 1'b0, 0, 1'b0, 1'b0);
        check("b2b_latch", 32'(latch_cnt), 32'd2);
        check("b2b_drop", 32'(drop_cnt), 32'd0);
        check("b2b_stalls", 32'(stall_cnt), 32'd2);
        reset_n       = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        check_idle_outputs("midframe_reset");
`ifdef RX_FIFO_WR_CTRL_STATS_EN
        check("stat_reset", {stat_good_cnt | stat_drop_cnt | stat_ovf_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // A clean frame after reset must commit: nothing stale survives from the aborted frame.
        run_frame(good64, 99);

        check("exclusive_pulses", 32'(excl_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
